// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: generates the PC, issues requests to instruction memory,
// and queues returned words in order for decode. A redirect flushes the queue and drops stale responses.
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_stall,
    output logic            id_valid,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode
);

    localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [PW-1:0]   LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW:0]     DEPTH_W    = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready.
    // The address is held until it transfers or a redirect replaces it. A decode transfer
    // happens on id_valid && !id_stall. imem responses carry no ready signal: they are
    // always accepted and arrive in request order.

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [PW-1:0]   q_rd;
    logic [PW-1:0]   q_wr;
    logic [PW-1:0]   tag_rd;
    logic [PW-1:0]   tag_wr;
    logic [XLEN-1:0] q_inst [DEPTH];
    logic [XLEN-1:0] q_pc   [DEPTH];
    logic [XLEN-1:0] tag_pc [DEPTH];

    logic            pop;
    logic            req_fire;
    logic            rsp_take;
    logic            rsp_drop;
    logic            push;
    logic [CW:0]     occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        pop       = id_valid & ~id_stall;
        // A word leaving the queue this cycle frees a slot for a new request.
        occupancy = {1'b0, outstanding} + {1'b0, q_count} - {{CW{1'b0}}, pop};
        imem_req_valid = rst_n & ~redirect_valid & (occupancy < DEPTH_W);
        req_fire  = imem_req_valid & imem_req_ready;
        // A response with nothing owed is a leftover from before a reset and is ignored.
        rsp_take  = imem_rsp_valid & (outstanding != '0);
        rsp_drop  = rsp_take & (redirect_valid | (drop_cnt != '0));
        push      = rsp_take & ~rsp_drop;
    end

    assign imem_req_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC & ALIGN_MASK;
            outstanding <= '0;
            drop_cnt    <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc & ALIGN_MASK;
            end else if (req_fire) begin
                pc <= pc + XLEN'(4);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            // Every response still owed at a redirect belongs to the old path.
            if (redirect_valid) begin
                drop_cnt <= outstanding - CW'(rsp_take);
            end else if (rsp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (req_fire) begin
                tag_wr <= ptr_inc(tag_wr);
            end
            if (rsp_take) begin
                tag_rd <= ptr_inc(tag_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_wr] <= pc;
        end
        if (push) begin
            q_inst[q_wr] <= imem_rsp_data;
            q_pc[q_wr]   <= tag_pc[tag_rd];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_rd    <= '0;
            q_wr    <= '0;
            q_count <= '0;
        end else if (redirect_valid) begin
            q_rd    <= '0;
            q_wr    <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                q_wr <= ptr_inc(q_wr);
            end
            if (pop) begin
                q_rd <= ptr_inc(q_rd);
            end
            q_count <= q_count + CW'(push) - CW'(pop);
        end
    end

    assign id_valid  = (q_count != '0);
    assign id_inst   = id_valid ? q_inst[q_rd] : NOP_INST;
    assign id_pc     = id_valid ? q_pc[q_rd] : '0;
    assign id_opcode = id_inst[6:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a scripted/random imem responder plus a program-order model
// of the expected fetch stream (sequential PCs from reset or redirect targets).
module tb_if_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 3;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    if_fetch_unit #(
        .XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INST(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_stall(id_stall), .id_valid(id_valid), .id_inst(id_inst),
        .id_pc(id_pc), .id_opcode(id_opcode)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    logic [31:0] exp_q[$];
    logic [31:0] exp_req_addr;
    logic [31:0] pend_data[$];
    int          pend_due[$];
    int          cyc;
    int          last_due;
    int          lat;
    int          tb_occ;
    logic        data_mode;

    // per-cycle samples and model expectations at sample time
    logic        s_req_valid, s_id_valid;
    logic [31:0] s_req_addr, s_id_pc, s_id_inst;
    logic [31:0] e_head_pc, e_head_inst, e_req_addr;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        if (data_mode) return a ^ 32'h5A3C_96E1;
        return a;
    endfunction

    task automatic model_reset(input logic [31:0] target);
        logic [31:0] a;
        a = target & 32'hFFFF_FFFC;
        exp_q.delete();
        exp_q.push_back(a);
        while (exp_q.size() < 4) exp_q.push_back(exp_q[exp_q.size() - 1] + 32'd4);
        exp_req_addr = a;
        tb_occ = 0;
    endtask

    // driver: one clock cycle, starting and ending on a falling edge
    task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc,
                         input logic ready);
        logic hs, pp, rs;
        id_stall       = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = ready;
        if (pend_data.size() != 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_data[0];
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_id_valid  = id_valid;
        s_id_pc     = id_pc;
        s_id_inst   = id_inst;
        e_head_pc   = exp_q[0];
        e_head_inst = inst_of(exp_q[0]);
        e_req_addr  = exp_req_addr;
        hs = imem_req_valid & ready;
        pp = id_valid & ~stall;
        rs = imem_rsp_valid;
        @(posedge clk);
        if (rs) begin
            void'(pend_data.pop_front());
            void'(pend_due.pop_front());
        end
        if (hs) begin
            int due;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_data.push_back(inst_of(s_req_addr));
            pend_due.push_back(due);
            exp_req_addr = exp_req_addr + 32'd4;
            tb_occ++;
        end
        if (redir) begin
            model_reset(rpc);
        end else if (pp) begin
            void'(exp_q.pop_front());
            while (exp_q.size() < 4) exp_q.push_back(exp_q[exp_q.size() - 1] + 32'd4);
            tb_occ--;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n    = 1'b1;
        model_reset(RESET_PC);
        cyc      = 1;
        last_due = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        n_cmp++; if (id_inst !== NOP) begin n_fail++; $display("FAIL reset_id_inst: got %h want %h", id_inst, NOP); end
        n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
        n_cmp++; if (id_opcode !== 7'h13) begin n_fail++; $display("FAIL reset_id_opcode: got %h want 13", id_opcode); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        @(negedge clk);
        release_reset();
    endtask

    task automatic test_stream();
        logic ev;
        data_mode = 1'b0;
        lat = 1;
        for (int k = 1; k <= 20; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (k == 1) begin
                n_cmp++;
                if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
                    n_fail++; $display("FAIL first_req: got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, RESET_PC);
                end
            end
            if (s_req_valid) begin
                n_cmp++;
                if (s_req_addr !== e_req_addr) begin n_fail++; $display("FAIL stream_addr: got %h want %h", s_req_addr, e_req_addr); end
            end
            ev = (k >= 3);
            n_cmp++;
            if (s_id_valid !== ev) begin n_fail++; $display("FAIL stream_valid cyc%0d: got %b want %b", k, s_id_valid, ev); end
            if (s_id_valid) begin
                n_cmp++;
                if (s_id_pc !== e_head_pc || s_id_inst !== e_head_inst) begin
                    n_fail++; $display("FAIL stream_head: got pc=%h inst=%h want pc=%h inst=%h", s_id_pc, s_id_inst, e_head_pc, e_head_inst);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic st;
        for (int k = 0; k < 16; k++) begin
            st = (k >= 5 && k <= 8);
            cycle(st, 1'b0, '0, 1'b1);
            n_cmp++;
            if (s_id_valid !== 1'b1 || s_id_pc !== e_head_pc || s_id_inst !== e_head_inst) begin
                n_fail++; $display("FAIL stall_head k%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, s_id_valid, s_id_pc, s_id_inst, e_head_pc, e_head_inst);
            end
            n_cmp++;
            if (tb_occ > DEPTH) begin n_fail++; $display("FAIL stall_occupancy: got %0d want <= %0d", tb_occ, DEPTH); end
            if (k == 8) begin
                n_cmp++;
                if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_full_no_req: got %b want 0", s_req_valid); end
            end
            if (s_req_valid) begin
                n_cmp++;
                if (s_req_addr !== e_req_addr) begin n_fail++; $display("FAIL stall_addr: got %h want %h", s_req_addr, e_req_addr); end
            end
        end
    endtask

    task automatic test_redirect();
        data_mode = 1'b1;
        lat = 1;
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b1, 32'h100, 1'b1);
        n_cmp++;
        if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_no_req: got %b want 0", s_req_valid); end
        for (int j = 1; j <= 10; j++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (j == 1) begin
                n_cmp++;
                if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
                    n_fail++; $display("FAIL redir_first_req: got v=%b a=%h want v=1 a=100", s_req_valid, s_req_addr);
                end
            end
            if (j < 3) begin
                n_cmp++;
                if (s_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush j%0d: got %b want 0", j, s_id_valid); end
            end
            if (j == 3) begin
                n_cmp++;
                if (s_id_valid !== 1'b1 || s_id_pc !== 32'h100) begin
                    n_fail++; $display("FAIL redir_latency: got v=%b pc=%h want v=1 pc=100", s_id_valid, s_id_pc);
                end
            end
            if (s_id_valid) begin
                n_cmp++;
                if (s_id_pc < 32'h100 || s_id_pc !== e_head_pc || s_id_inst !== e_head_inst) begin
                    n_fail++; $display("FAIL redir_head: got pc=%h inst=%h want pc=%h inst=%h", s_id_pc, s_id_inst, e_head_pc, e_head_inst);
                end
            end
        end
    endtask

    task automatic test_misaligned();
        cycle(1'b0, 1'b1, 32'h102, 1'b1);
        for (int j = 1; j <= 6; j++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (j == 1) begin
                n_cmp++;
                if (s_req_valid !== 1'b1 || s_req_addr !== 32'h100) begin
                    n_fail++; $display("FAIL misaligned_addr: got v=%b a=%h want v=1 a=100", s_req_valid, s_req_addr);
                end
            end
            if (j == 3) begin
                n_cmp++;
                if (s_id_valid !== 1'b1 || s_id_pc !== 32'h100 || s_id_inst !== inst_of(32'h100)) begin
                    n_fail++; $display("FAIL misaligned_pc: got v=%b pc=%h inst=%h want v=1 pc=100", s_id_valid, s_id_pc, s_id_inst);
                end
            end
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] wrap_tab [4];
        wrap_tab = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (j == 3) begin
                n_cmp++;
                if (s_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_req_addr: got %h want 0", s_req_addr); end
            end
            if (j >= 3 && j <= 6) begin
                n_cmp++;
                if (s_id_valid !== 1'b1 || s_id_pc !== wrap_tab[j-3] || s_id_inst !== inst_of(wrap_tab[j-3])) begin
                    n_fail++; $display("FAIL wrap_pc j%0d: got v=%b pc=%h want pc=%h", j, s_id_valid, s_id_pc, wrap_tab[j-3]);
                end
            end
        end
    endtask

    task automatic test_ready_latency();
        logic rdy, prev_hold;
        logic [31:0] prev_addr;
        lat = 3;
        data_mode = 1'b1;
        cycle(1'b0, 1'b1, 32'h400, 1'b1);
        prev_hold = 1'b0;
        prev_addr = '0;
        for (int k = 1; k <= 60; k++) begin
            rdy = 1'($urandom_range(0, 1));
            cycle(1'b0, (k == 30), 32'h800, rdy);
            if (prev_hold) begin
                n_cmp++;
                if (s_req_valid !== 1'b1 || s_req_addr !== prev_addr) begin
                    n_fail++; $display("FAIL ready_hold: got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, prev_addr);
                end
            end
            if (s_req_valid && k != 30) begin
                n_cmp++;
                if (s_req_addr !== e_req_addr) begin n_fail++; $display("FAIL ready_addr: got %h want %h", s_req_addr, e_req_addr); end
            end
            if (s_id_valid) begin
                n_cmp++;
                if (s_id_pc !== e_head_pc || s_id_inst !== e_head_inst) begin
                    n_fail++; $display("FAIL ready_head: got pc=%h inst=%h want pc=%h inst=%h", s_id_pc, s_id_inst, e_head_pc, e_head_inst);
                end
            end
            prev_hold = s_req_valid & ~rdy & (k != 30);
            prev_addr = e_req_addr;
        end
    endtask

    task automatic test_random();
        logic st, rd, rdy;
        logic [31:0] tgt;
        data_mode = 1'b1;
        for (int k = 0; k < 200; k++) begin
            lat = $urandom_range(1, 4);
            st  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = $urandom();
            cycle(st, rd, tgt, rdy);
            if (rd) begin
                n_cmp++;
                if (s_req_valid !== 1'b0) begin n_fail++; $display("FAIL rand_redir_req: got %b want 0", s_req_valid); end
            end else if (s_req_valid) begin
                n_cmp++;
                if (s_req_addr !== e_req_addr) begin n_fail++; $display("FAIL rand_addr: got %h want %h", s_req_addr, e_req_addr); end
            end
            if (s_id_valid) begin
                n_cmp++;
                if (s_id_pc !== e_head_pc || s_id_inst !== e_head_inst) begin
                    n_fail++; $display("FAIL rand_head: got pc=%h inst=%h want pc=%h inst=%h", s_id_pc, s_id_inst, e_head_pc, e_head_inst);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic ev;
        lat = 3;
        data_mode = 1'b1;
        cycle(1'b0, 1'b1, 32'h200, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_id_valid: got %b want 0", id_valid); end
        n_cmp++; if (id_inst !== NOP) begin n_fail++; $display("FAIL midrst_id_inst: got %h want %h", id_inst, NOP); end
        n_cmp++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_id_pc: got %h want 0", id_pc); end
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); end
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            n_cmp++;
            if (s_id_valid !== 1'b0 || s_req_valid !== 1'b0) begin
                n_fail++; $display("FAIL midrst_hold: got id_v=%b req_v=%b want 0 0", s_id_valid, s_req_valid);
            end
        end
        // one stale word still on its way back lands in the first cycle after release
        pend_data.delete();
        pend_due.delete();
        pend_data.push_back(32'h0BAD_F00D);
        pend_due.push_back(0);
        lat = 1;
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            if (k == 1) begin
                n_cmp++;
                if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
                    n_fail++; $display("FAIL midrst_first_req: got v=%b a=%h want v=1 a=%h", s_req_valid, s_req_addr, RESET_PC);
                end
            end
            ev = (k >= 3);
            n_cmp++;
            if (s_id_valid !== ev) begin n_fail++; $display("FAIL midrst_valid k%0d: got %b want %b", k, s_id_valid, ev); end
            if (s_id_valid) begin
                n_cmp++;
                if (s_id_pc !== e_head_pc || s_id_inst !== e_head_inst) begin
                    n_fail++; $display("FAIL midrst_head: got pc=%h inst=%h want pc=%h inst=%h", s_id_pc, s_id_inst, e_head_pc, e_head_inst);
                end
            end
        end
    endtask

    // invariants, checked every cycle while out of reset
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            n_cmp++;
            if (id_opcode !== id_inst[6:0]) begin
                n_fail++; $display("FAIL inv_opcode: got %h want %h", id_opcode, id_inst[6:0]);
            end
            n_cmp++;
            if (int'(dut.outstanding) + int'(dut.q_count) > DEPTH) begin
                n_fail++; $display("FAIL inv_occupancy: got %0d want <= %0d", int'(dut.outstanding) + int'(dut.q_count), DEPTH);
            end
            n_cmp++;
            if (dut.drop_cnt > dut.outstanding) begin
                n_fail++; $display("FAIL inv_drop: got drop=%0d want <= %0d", dut.drop_cnt, dut.outstanding);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        pend_data.delete();
        pend_due.delete();
        data_mode = 1'b0;
        lat = 1;
        cyc = 0;
        last_due = 0;
        tb_occ = 0;
        model_reset(RESET_PC);
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_pc_wrap();
        test_ready_latency();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
